gpr_scoreboard_bank: RTL and testbench

- Parametrised successor to the decode-stage general register file.
- Provides NUM_RD independent read ports, one commit (write) port, and a per-register pending-write scoreboard.
- The decode stage marks a destination register pending at issue and the writeback stage clears it at commit. Decode then stalls on busy sources instead of needing a forward-select for every producer.
- Sits in decode; the write port is driven from writeback.

---
 rtl/gpr_scoreboard_bank.sv | 125 ++++++++++++
 tb/tb_gpr_scoreboard_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard_bank.sv
// gpr_scoreboard_bank: decode-stage register file with a per-register
// pending-write scoreboard. Decode marks a destination pending at issue,
// writeback clears it at commit, and decode stalls on busy sources.
//
// Optional feature macro: GPR_SCOREBOARD_BYPASS_EN
//   defined   : same-cycle commit is forwarded to every read port and
//               removed from the busy computation.
//   undefined : reads see the array only; busy clears one cycle after commit.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (array, counters, err)
//   rd_addr      NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_use       per-port "operand consumed" qualifier
//   rd_data      NUM_RD packed read data (combinational)
//   rd_busy      per-port pending-write flag (combinational)
//   stall        any used operand is busy (combinational)
//   issue_valid  mark issue_addr pending
//   issue_addr   destination register of the issuing instruction
//   issue_ready  issue accepted when issue_valid & issue_ready (combinational)
//   wr_en        commit write enable
//   wr_addr      commit destination
//   wr_data      commit data
//   err          sticky: commit to a non-zero register with no pending write
module gpr_scoreboard_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_use,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       stall,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       err
);

  localparam int unsigned REG_COUNT = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [REG_COUNT];
  logic [DATA_W-1:0] mem_d [REG_COUNT];
  logic [PEND_W-1:0] cnt_q [REG_COUNT];
  logic [PEND_W-1:0] cnt_d [REG_COUNT];
  logic              err_q;
  logic              err_d;

  logic commit;
  logic issue_acc;
  logic same_reg;

  // Register 0 is hardwired: commits and issues to it are dropped here.
  assign commit    = wr_en && (wr_addr != '0);
  assign same_reg  = (issue_addr == wr_addr);

  // Full counter blocks issue unless a same-cycle commit frees a slot.
  assign issue_ready = !((issue_addr != '0) && (cnt_q[issue_addr] == '1)
                         && !(commit && same_reg));
  assign issue_acc   = issue_valid && issue_ready && (issue_addr != '0);

  // Read ports
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
`ifdef GPR_SCOREBOARD_BYPASS_EN
    logic hit;
    assign hit = commit && (wr_addr == addr);
    assign rd_data[g*DATA_W +: DATA_W] = hit ? wr_data : mem_q[addr];
    assign rd_busy[g] = (cnt_q[addr] - PEND_W'(hit)) != '0;
`else
    assign rd_data[g*DATA_W +: DATA_W] = mem_q[addr];
    assign rd_busy[g] = cnt_q[addr] != '0;
`endif
  end

  assign stall = |(rd_use & rd_busy);
  assign err   = err_q;

  // Next-state: array write, counter update, sticky error
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    err_d = err_q;

    if (commit) begin
      mem_d[wr_addr] = wr_data;
      if (cnt_q[wr_addr] == '0) begin
        err_d = 1'b1;
      end
    end

    // Issue and commit to the same register cancel; otherwise each moves
    // its own counter. issue_ready guarantees the increment never wraps.
    if (issue_acc && !(commit && same_reg)) begin
      cnt_d[issue_addr] = cnt_q[issue_addr] + PEND_W'(1);
    end
    if (commit && !(issue_acc && same_reg) && (cnt_q[wr_addr] != '0)) begin
      cnt_d[wr_addr] = cnt_q[wr_addr] - PEND_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < REG_COUNT; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_gpr_scoreboard_bank.sv
module tb_gpr_scoreboard_bank;

`ifdef GPR_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err;

  gpr_scoreboard_bank #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .PEND_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_ready(issue_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ruse;
    logic        iv;
    logic [4:0]  ia;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rst;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        stl;
    logic        rdy;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] ruse,
    input logic iv, input logic [4:0] ia,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic rst,
    input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy,
    input logic stl, input logic rdy, input logic er);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.ruse = ruse; v.iv = iv; v.ia = ia;
    v.we = we; v.wa = wa; v.wd = wd; v.rst = rst;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.stl = stl; v.rdy = rdy; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector after the rising edge, compare at the falling edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    reset       = v.rst;
    rd_addr     = {v.ra1, v.ra0};
    rd_use      = v.ruse;
    issue_valid = v.iv;
    issue_addr  = v.ia;
    wr_en       = v.we;
    wr_addr     = v.wa;
    wr_data     = v.wd;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty step %0d", idx);
    end else begin
      e = exp_q.pop_front();
      chk("rd_data0", idx, rd_data[31:0], e.d0);
      chk("rd_data1", idx, rd_data[63:32], e.d1);
      chk("rd_busy", idx, 32'(rd_busy), 32'(e.busy));
      chk("stall", idx, 32'(stall), 32'(e.stl));
      chk("issue_ready", idx, 32'(issue_ready), 32'(e.rdy));
      chk("err", idx, 32'(err), 32'(e.er));
    end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; rd_use = '0; issue_valid = 1'b0;
    issue_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);

    //                ra0 ra1 use iv ia  we wa wd          rst  d0  d1  busy stl rdy err
    // reset state
    vecs.push_back(mk(5, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    // issue r8, then stall on it, then commit 0x1234
    vecs.push_back(mk(8, 0, 2'b01, 1, 8, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    vecs.push_back(mk(8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0));
    vecs.push_back(mk(8, 0, 2'b01, 0, 0, 1, 8, 32'h1234, 0,
                      BYP ? 32'h1234 : 32'h0, 0, BYP ? 2'b00 : 2'b01, !BYP, 1, 0));
    vecs.push_back(mk(8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 2'b00, 0, 1, 0));
    // fill r3 to max
    vecs.push_back(mk(3, 8, 2'b00, 1, 3, 0, 0, 0, 0, 0, 32'h1234, 2'b00, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 1, 3, 0, 0, 0, 0, 0, 32'h1234, 2'b01, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 1, 3, 0, 0, 0, 0, 0, 32'h1234, 2'b01, 0, 1, 0));
    // full: ready low regardless of issue_valid
    vecs.push_back(mk(3, 8, 2'b00, 0, 3, 0, 0, 0, 0, 0, 32'h1234, 2'b01, 0, 0, 0));
    // issue + commit same cycle: ready, count unchanged at 3
    vecs.push_back(mk(3, 8, 2'b00, 1, 3, 1, 3, 32'h33, 0,
                      BYP ? 32'h33 : 32'h0, 32'h1234, 2'b01, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 1, 3, 0, 0, 0, 0, 32'h33, 32'h1234, 2'b01, 0, 0, 0));
    // three commits drain r3
    vecs.push_back(mk(3, 8, 2'b00, 0, 0, 1, 3, 32'h44, 0,
                      BYP ? 32'h44 : 32'h33, 32'h1234, 2'b01, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 0, 0, 1, 3, 32'h55, 0,
                      BYP ? 32'h55 : 32'h44, 32'h1234, 2'b01, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 0, 0, 1, 3, 32'h66, 0,
                      BYP ? 32'h66 : 32'h55, 32'h1234, BYP ? 2'b00 : 2'b01, 0, 1, 0));
    vecs.push_back(mk(3, 8, 2'b00, 0, 0, 0, 0, 0, 0, 32'h66, 32'h1234, 2'b00, 0, 1, 0));
    // register 0 ignores issue and commit
    vecs.push_back(mk(0, 3, 2'b11, 1, 0, 0, 0, 0, 0, 0, 32'h66, 2'b00, 0, 1, 0));
    vecs.push_back(mk(0, 3, 2'b11, 0, 0, 1, 0, 32'hFFFF, 0, 0, 32'h66, 2'b00, 0, 1, 0));
    vecs.push_back(mk(0, 3, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h66, 2'b00, 0, 1, 0));
    // unmatched commit to r9: data written, err sticky
    vecs.push_back(mk(5, 0, 2'b00, 0, 0, 1, 9, 32'hABCD, 0, 0, 0, 2'b00, 0, 1, 0));
    vecs.push_back(mk(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'hABCD, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(9, 9, 2'b00, 0, 0, 0, 0, 0, 0, 32'hABCD, 32'hABCD, 2'b00, 0, 1, 1));
    // three pending on r4, then reset mid-stream
    vecs.push_back(mk(4, 0, 2'b01, 1, 4, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(4, 0, 2'b01, 1, 4, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 1));
    vecs.push_back(mk(4, 0, 2'b01, 1, 4, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 1));
    vecs.push_back(mk(4, 9, 2'b11, 0, 4, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0));
    // stale commit after reset sets err
    vecs.push_back(mk(5, 9, 2'b11, 0, 0, 1, 4, 32'h77, 0, 0, 0, 2'b00, 0, 1, 0));
    vecs.push_back(mk(4, 9, 2'b11, 0, 0, 0, 0, 0, 0, 32'h77, 0, 2'b00, 0, 1, 1));

    foreach (vecs[i]) step(vecs[i], i);

    // Held issue on r10 saturates at 3 accepted, busy seen on port 1
    for (int k = 0; k < 5; k++) begin
      step(mk(0, 10, 2'b10, 1, 10, 0, 0, 0, 0, 0, 0,
              (k > 0) ? 2'b10 : 2'b00, k > 0, k < 3, 1), 100 + k);
    end
    // Exactly three commits drain it
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 10, 2'b10, 0, 0, 1, 10, 32'h100 + 32'(k), 0, 0,
              BYP ? 32'h100 + 32'(k) : ((k == 0) ? 32'h0 : 32'h100 + 32'(k - 1)),
              (BYP && k == 2) ? 2'b00 : 2'b10, !(BYP && k == 2), 1, 1), 200 + k);
    end
    step(mk(0, 10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 32'h102, 2'b00, 0, 1, 1), 300);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
